// File: rtl/quadra_ofifo_pkg.sv
// Shared types for the quadratic evaluator output path: result word, strobe,
// default buffer depth and the drop counter type.
package quadra_ofifo_pkg;

  typedef logic [15:0] y_t;
  typedef logic        dv_t;
  typedef logic [7:0]  drop_cnt_t;

  localparam int        QOF_DEPTH = 8;
  localparam drop_cnt_t DROP_MAX  = 8'hFF;

endpackage : quadra_ofifo_pkg

// File: rtl/quadra_ofifo_ram.sv
// DEPTH x y_t register array: one synchronous write port, one asynchronous
// read port.
module quadra_ofifo_ram
  import quadra_ofifo_pkg::*;
#(
  parameter int DEPTH = QOF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  y_t            wdata,
  input  logic [AW-1:0] raddr,
  output y_t            rdata
);

  y_t mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count define which entries are
  // meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : quadra_ofifo_ram

// File: rtl/quadra_ofifo.sv
// First-word-fall-through buffer behind the quadratic evaluator; words that
// arrive while full and not draining are dropped, flagged and counted.
module quadra_ofifo
  import quadra_ofifo_pkg::*;
#(
  parameter  int DEPTH = QOF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  y_t            y,
  input  dv_t           y_dv,
  output y_t            out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output drop_cnt_t     drop_cnt,
  input  logic          clr_ovf
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  y_t            rd_data;

  // Flags decode registered count only, so no path from y_dv or out_ready.
  assign out_valid = (count != '0);
  assign full      = (count == FULL_COUNT);

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign pop  = out_valid && out_ready;
  assign push = y_dv && (!full || pop);
  assign drop = y_dv && full && !pop;

  quadra_ofifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr),
    .wdata (y),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign out_data = out_valid ? rd_data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear beats a coincident drop; the counter saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule : quadra_ofifo

// File: tb/tb_quadra_ofifo.sv
// Self-checking bench for quadra_ofifo against a queue-based reference model.
module tb_quadra_ofifo;
  import quadra_ofifo_pkg::*;

  localparam int DEPTH = 8;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  y_t        y = '0;
  dv_t       y_dv = 1'b0;
  y_t        out_data;
  logic      out_valid;
  logic      out_ready = 1'b0;
  logic [3:0] count;
  logic      full;
  logic      overflow;
  drop_cnt_t drop_cnt;
  logic      clr_ovf = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue contents plus overflow flag and drop count.
  y_t q[$];
  bit m_ovf = 1'b0;
  int m_drops = 0;

  always #5 clk = ~clk;

  quadra_ofifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .y         (y),
    .y_dv      (y_dv),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  function automatic y_t exp_head();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  // Drive one cycle of inputs, update the model at the edge, return #1 later.
  task automatic step(input y_t yv, input logic dv, input logic rdy,
                      input logic clr, input logic rs);
    bit m_pop, m_full, m_push, m_drop;
    y = yv; y_dv = dv; out_ready = rdy; clr_ovf = clr; rst = rs;
    m_pop  = (q.size() != 0) && rdy;
    m_full = (q.size() == DEPTH);
    m_push = dv && (!m_full || m_pop);
    m_drop = dv && m_full && !m_pop;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_drops = 0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(yv);
      if (clr) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end else if (m_drop) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    #1;
    y_dv = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (count !== 4'd0 || out_valid !== 1'b0 || full !== 1'b0 || out_data !== 16'h0 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: count=%0d valid=%b full=%b data=%h ovf=%b drops=%0d, required all zero",
               count, out_valid, full, out_data, overflow, drop_cnt);
    end
  endtask

  task automatic test_basic();
    y_t words[3] = '{16'h0011, 16'h0022, 16'h0033};
    foreach (words[i]) step(words[i], 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count !== 4'd3) begin
      miscompares++;
      $display("FAIL basic_count: got %0d, required 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== words[i]) begin
        miscompares++;
        $display("FAIL basic_order[%0d]: valid=%b data=%h, required 1/%h", i, out_valid, out_data, words[i]);
      end
      step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      miscompares++;
      $display("FAIL basic_empty: valid=%b data=%h, required 0/0000", out_valid, out_data);
    end
  endtask

  task automatic test_overflow();
    y_t words[10];
    foreach (words[i]) words[i] = y_t'($urandom);
    foreach (words[i]) step(words[i], 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL overflow: full=%b count=%0d ovf=%b drops=%0d, required 1/8/1/2",
               full, count, overflow, drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (out_data !== words[i]) begin
        miscompares++;
        $display("FAIL overflow_drain[%0d]: got %h, required %h", i, out_data, words[i]);
      end
      step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    vectors++;
    if (count !== 4'd0) begin
      miscompares++;
      $display("FAIL overflow_drained: count=%0d, required 0", count);
    end
    step('0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full_passthrough();
    for (int i = 0; i < DEPTH; i++) step(y_t'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(y_t'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (count !== 4'd8 || drop_cnt !== 8'd0 || overflow !== 1'b0 || out_data !== exp_head()) begin
        miscompares++;
        $display("FAIL full_pass[%0d]: count=%0d drops=%0d ovf=%b data=%h, required 8/0/0/%h",
                 i, count, drop_cnt, overflow, out_data, exp_head());
      end
    end
    while (q.size() != 0) begin
      vectors++;
      if (out_data !== exp_head()) begin
        miscompares++;
        $display("FAIL full_pass_drain: got %h, required %h", out_data, exp_head());
      end
      step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    y_t w;
    for (int i = 0; i < 20; i++) begin
      w = y_t'($urandom);
      step(w, 1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (count > 4'd1 || out_valid !== 1'b1 || out_data !== w) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: count=%0d valid=%b data=%h, required <=1/1/%h",
                 i, count, out_valid, out_data, w);
      end
    end
    step('0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < DEPTH + 300; i++) step(y_t'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== 4'd8) begin
      miscompares++;
      $display("FAIL saturation: drops=%0d ovf=%b count=%0d, required 255/1/8", drop_cnt, overflow, count);
    end
    step(y_t'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_wins: drops=%0d ovf=%b, required 0/0", drop_cnt, overflow);
    end
  endtask

  task automatic test_mid_reset();
    y_t w;
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(y_t'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count !== 4'd5) begin
      miscompares++;
      $display("FAIL mid_reset_fill: count=%0d, required 5", count);
    end
    step(y_t'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: count=%0d valid=%b, required 0/0", count, out_valid);
    end
    w = y_t'($urandom);
    step(w, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== w || count !== 4'd1) begin
      miscompares++;
      $display("FAIL mid_reset_first: valid=%b data=%h count=%0d, required 1/%h/1", out_valid, out_data, count, w);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      step(y_t'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 200) == 0));
      vectors++;
      if (count !== 4'(q.size()) || out_valid !== (q.size() != 0) || full !== (q.size() == DEPTH) ||
          out_data !== exp_head() || overflow !== m_ovf || drop_cnt !== 8'(m_drops)) begin
        miscompares++;
        $display("FAIL random[%0d]: count=%0d/%0d valid=%b full=%b data=%h/%h ovf=%b/%b drops=%0d/%0d",
                 i, count, q.size(), out_valid, full, out_data, exp_head(), overflow, m_ovf,
                 drop_cnt, m_drops);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_passthrough();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_quadra_ofifo
